sobel_frame_ctrl: RTL

SOBEL_FRAME_CTRL -- requirements
Module: sobel_frame_ctrl

---
 rtl/sobel_frame_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/sobel_frame_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sobel_frame_ctrl                                           |
// | Description : Frame sequencer for the Sobel pipeline. Latches per-frame  |
// |               config, gates the input handshake, tracks pixel position   |
// |               for border flagging and counts outputs to detect frame end.|
// | Options     : define SOBEL_CTRL_STALL_CNT_EN to add the stall_cnt output |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module sobel_frame_ctrl #(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cfg_start,
   input  logic [8:0]  cfg_threshold,
   input  logic        cfg_sobel_en,
   input  logic        pix_valid_i,
   output logic        pix_ready_o,
   output logic        valid_m,
   input  logic        ready_m,
   output logic        zero_valid,
   output logic [8:0]  threshold,
   output logic        sobel_en,
   input  logic        valid_s,
   input  logic        ready_s,
   output logic        busy,
`ifdef SOBEL_CTRL_STALL_CNT_EN
   output logic [31:0] stall_cnt,
`endif
   output logic        frame_done
);

   localparam int c_total = IMG_W * IMG_H;
   localparam int c_xw    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int c_yw    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int c_ow    = $clog2(c_total + 1);

   localparam logic [c_xw-1:0] c_x_last    = c_xw'(IMG_W - 1);
   localparam logic [c_yw-1:0] c_y_last    = c_yw'(IMG_H - 1);
   localparam logic [c_ow-1:0] c_out_total = c_ow'(c_total);
   localparam logic [c_ow-1:0] c_out_last  = c_ow'(c_total - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t          r_state;
   logic [c_xw-1:0] r_x;
   logic [c_yw-1:0] r_y;
   logic [c_ow-1:0] r_out_cnt;
   logic [8:0]      r_threshold;
   logic            r_sobel_en;
   logic            r_busy;
   logic            r_frame_done;

   logic w_run;
   logic w_active;
   logic w_start;
   logic w_in;
   logic w_out;
   logic w_x_last;
   logic w_y_last;
   logic w_out_reach;

   assign w_run    = (r_state == S_RUN);
   assign w_active = (r_state == S_RUN) || (r_state == S_DRAIN);
   assign w_start  = cfg_start && (r_state == S_IDLE);

   assign valid_m     = pix_valid_i & w_run;
   assign pix_ready_o = ready_m & w_run;

   assign w_in     = valid_m & ready_m;
   assign w_out    = valid_s & ready_s & w_active;
   assign w_x_last = (r_x == c_x_last);
   assign w_y_last = (r_y == c_y_last);

   assign zero_valid = (r_x == '0) || w_x_last || (r_y == '0) || w_y_last;

   // Completion is seen on the same edge as the final output beat.
   assign w_out_reach = (r_out_cnt == c_out_total) ||
                        (w_out && (r_out_cnt == c_out_last));

   assign threshold  = r_threshold;
   assign sobel_en   = r_sobel_en;
   assign busy       = r_busy;
   assign frame_done = r_frame_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_x          <= '0;
         r_y          <= '0;
         r_out_cnt    <= '0;
         r_threshold  <= '0;
         r_sobel_en   <= 1'b0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         if (w_in) begin
            if (w_x_last) begin
               r_x <= '0;
               r_y <= w_y_last ? '0 : r_y + 1'b1;
            end else begin
               r_x <= r_x + 1'b1;
            end
         end

         if (w_out && (r_out_cnt != c_out_total)) begin
            r_out_cnt <= r_out_cnt + 1'b1;
         end

         case (r_state)
            S_IDLE: begin
               r_frame_done <= 1'b0;
               if (cfg_start) begin
                  r_state     <= S_RUN;
                  r_busy      <= 1'b1;
                  r_threshold <= cfg_threshold;
                  r_sobel_en  <= cfg_sobel_en;
                  r_x         <= '0;
                  r_y         <= '0;
                  r_out_cnt   <= '0;
               end
            end
            S_RUN: begin
               if (w_in && w_x_last && w_y_last) begin
                  r_state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (w_out_reach) begin
                  r_state      <= S_DONE;
                  r_frame_done <= 1'b1;
               end
            end
            S_DONE: begin
               r_state      <= S_IDLE;
               r_busy       <= 1'b0;
               r_frame_done <= 1'b0;
            end
            default: begin
               r_state      <= S_IDLE;
               r_busy       <= 1'b0;
               r_frame_done <= 1'b0;
            end
         endcase
      end
   end

`ifdef SOBEL_CTRL_STALL_CNT_EN
   logic [31:0] r_stall_cnt;

   // Counts cycles where the pipeline output is held off by the sink.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
      end else if (w_start) begin
         r_stall_cnt <= '0;
      end else if (w_active && valid_s && !ready_s &&
                   (r_stall_cnt != 32'hFFFF_FFFF)) begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign stall_cnt = r_stall_cnt;
`else
   logic w_unused_start;
   assign w_unused_start = w_start;
`endif

endmodule
`default_nettype wire
